// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared constants for the serial adder slice:
//     - default operand width and bits-per-clock
//     - FSM state encoding (plain localparams so legacy tools can consume it)
//     - helper that sizes the chunk counter
//   No ports; imported by serial_adder.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_BPC   = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width for 'chunks' steps; never narrower than one bit so the
    // single-chunk configuration (BPC == WIDTH) still has a legal vector.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   One-bit full adder used to build the per-clock chunk datapath.
//   Ports:
//     a, b  : addend bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder that processes BPC bits per clock, LSB chunk first.
//   An operation takes WIDTH/BPC RUN cycles followed by one DONE cycle, so a
//   new result is available every WIDTH/BPC + 2 cycles when start is held.
//
//   Parameters:
//     WIDTH : operand/result width (2..64)
//     BPC   : bits processed per clock, must divide WIDTH
//
//   Ports:
//     clk   : rising-edge clock
//     nrst  : asynchronous active-low reset
//     start : latch operands and begin (only honoured in IDLE)
//     a, b  : operands
//     cin   : carry into the LSB
//     sub   : (only with SERIAL_ADDER_SUB_EN) subtract; b is inverted at
//             latch time and cin=1 means "no borrow"
//     busy  : high in RUN and DONE
//     done  : one-cycle pulse, result registers just updated
//     sum   : registered result, held until the next done
//     cout  : registered carry out of the MSB (0 = borrow when subtracting)
//     ovf   : registered signed overflow
//
//   Build option: define SERIAL_ADDER_SUB_EN to add the sub port.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BPC   = DEFAULT_BPC
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             NUM_CHUNKS = WIDTH / BPC;
    localparam int             CW         = cnt_width(NUM_CHUNKS);
    localparam logic [CW-1:0]  LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("serial_adder: WIDTH must be in 2..64");
        end
        if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_bpc
            $error("serial_adder: BPC must divide WIDTH");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] b_eff;
    logic [BPC:0]     chain;
    logic [BPC-1:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;

    // Subtraction is folded into the operand latch: inverting b once means
    // the datapath below never needs to know which operation is running.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
`else
    assign b_eff = b;
`endif

    // ------------------------------------------------------------------
    // Chunk datapath: BPC full adders rippled, fed by the low BPC bits of
    // the operand shift registers and the carry flop.
    // ------------------------------------------------------------------
    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_fa
            fa_cell u_fa (
                .a  (a_sh_reg[gi]),
                .b  (b_sh_reg[gi]),
                .ci (chain[gi]),
                .s  (chunk_sum[gi]),
                .co (chain[gi+1])
            );
        end
    endgenerate

    // The accumulator fills from the top: after NUM_CHUNKS shifts the first
    // (LSB) chunk has landed in bits [BPC-1:0].
    assign acc_next   = (acc_reg >> BPC) | (WIDTH'(chunk_sum) << (WIDTH - BPC));
    assign last_chunk = (cnt_reg == LAST_CHUNK);

    // ------------------------------------------------------------------
    // Control and state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b_eff;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    a_sh_reg  <= a_sh_reg >> BPC;
                    b_sh_reg  <= b_sh_reg >> BPC;
                    carry_reg <= chain[BPC];
                    acc_reg   <= acc_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_chunk) begin
                        // All three result registers update on the same edge
                        // so observers never see a partially updated result.
                        sum_reg   <= acc_next;
                        cout_reg  <= chain[BPC];
                        ovf_reg   <= chain[BPC] ^ chain[BPC-1];
                        cnt_reg   <= '0;
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Drives two WIDTH=8 instances side by side (BPC=1 and BPC=4) from the same
//   stimulus: a table of directed vectors, a start-held-high sequence with a
//   changing operand, and a reset abort in the middle of RUN.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BPC(1)) u_dut1 (
        .clk   (clk),
        .nrst  (nrst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    serial_adder #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk   (clk),
        .nrst  (nrst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];
    int   nvec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] aval(input int k);
        return 8'(32'h20 + 32'h11 * k);
    endfunction

    // Called at the negedge on which start was raised. Drops start after the
    // start edge, then watches both instances for a bounded number of cycles.
    task automatic monitor_op(input string tag, input logic [7:0] es,
                              input logic ec, input logic ev);
        int         lat1 = -1;
        int         lat4 = -1;
        int         n1 = 0;
        int         n4 = 0;
        logic [7:0] s1 = '0;
        logic [7:0] s4 = '0;
        logic       c1 = 1'b0;
        logic       c4 = 1'b0;
        logic       v1 = 1'b0;
        logic       v4 = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy1 after start"}, 64'(busy1), 64'd1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done1) begin
                n1++;
                if (lat1 < 0) begin
                    lat1 = k; s1 = sum1; c1 = cout1; v1 = ovf1;
                end
            end
            if (done4) begin
                n4++;
                if (lat4 < 0) begin
                    lat4 = k; s4 = sum4; c4 = cout4; v4 = ovf4;
                end
            end
        end
        chk({tag, " lat1"}, 64'(lat1), 64'd8);
        chk({tag, " lat4"}, 64'(lat4), 64'd2);
        chk({tag, " ndone1"}, 64'(n1), 64'd1);
        chk({tag, " ndone4"}, 64'(n4), 64'd1);
        chk({tag, " sum1"}, 64'(s1), 64'(es));
        chk({tag, " cout1"}, 64'(c1), 64'(ec));
        chk({tag, " ovf1"}, 64'(v1), 64'(ev));
        chk({tag, " sum4"}, 64'(s4), 64'(es));
        chk({tag, " cout4"}, 64'(c4), 64'(ec));
        chk({tag, " ovf4"}, 64'(v4), 64'(ev));
        chk({tag, " sum1 held"}, 64'(sum1), 64'(es));
        chk({tag, " sum4 held"}, 64'(sum4), 64'(es));
        chk({tag, " busy1 idle"}, 64'(busy1), 64'd0);
        chk({tag, " busy4 idle"}, 64'(busy4), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd1;
        int nd4;
        int lost;

        // a, b, cin, sub, expected sum, cout, ovf (all hand computed)
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'h44, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[8] = '{8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1};
        nvec = 9;
`ifdef SERIAL_ADDER_SUB_EN
        vecs[9] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        nvec = 10;
        sub = 1'b0;
`endif

        nrst  = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset sum1", 64'(sum1), 64'd0);
        chk("reset busy1", 64'(busy1), 64'd0);
        chk("reset done1", 64'(done1), 64'd0);
        chk("reset cout1", 64'(cout1), 64'd0);
        chk("reset ovf1", 64'(ovf1), 64'd0);
        chk("reset busy4", 64'(busy4), 64'd0);
        chk("reset sum4", 64'(sum4), 64'd0);

        // Release reset and start on the very next edge
        nrst = 1'b1;
        for (int i = 0; i < nvec; i++) begin
            a     = vecs[i].a;
            b     = vecs[i].b;
            cin   = vecs[i].cin;
`ifdef SERIAL_ADDER_SUB_EN
            sub   = vecs[i].sub;
`endif
            start = 1'b1;
            monitor_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            $display("vec%0d a=%02h b=%02h cin=%0b -> sum1=%02h sum4=%02h cout1=%0b ovf1=%0b",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, sum1, sum4, cout1, ovf1);
        end
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif

        // Start held high for 20 cycles with a changing every cycle.
        // Operands are latched only at IDLE edges: every L+2 cycles.
        nd1 = 0;
        nd4 = 0;
        b   = 8'h01;
        cin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a     = aval(i);
            start = 1'b1;
            @(negedge clk);
            chk($sformatf("held%0d done1", i), 64'(done1), 64'((i % 10) == 8));
            chk($sformatf("held%0d done4", i), 64'(done4), 64'((i % 4) == 2));
            if (done1) begin
                nd1++;
                if (i >= 8)
                    chk($sformatf("held%0d sum1", i), 64'(sum1), 64'(8'(aval(i - 8) + 8'h01)));
            end
            if (done4) begin
                nd4++;
                if (i >= 2)
                    chk($sformatf("held%0d sum4", i), 64'(sum4), 64'(8'(aval(i - 2) + 8'h01)));
            end
        end
        start = 1'b0;
        chk("held ndone1", 64'(nd1), 64'd2);
        chk("held ndone4", 64'(nd4), 64'd5);
        $display("held-start sequence: done1 pulses=%0d done4 pulses=%0d", nd1, nd4);
        repeat (2) @(negedge clk);

        // Reset asserted in the 4th RUN cycle of the BPC=1 instance
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy1 before reset", 64'(busy1), 64'd1);
        nrst = 1'b0;
        #1;
        chk("abort sum1", 64'(sum1), 64'd0);
        chk("abort cout1", 64'(cout1), 64'd0);
        chk("abort ovf1", 64'(ovf1), 64'd0);
        chk("abort busy1", 64'(busy1), 64'd0);
        chk("abort done1", 64'(done1), 64'd0);
        chk("abort sum4", 64'(sum4), 64'd0);
        lost = 0;
        repeat (2) begin
            @(negedge clk);
            if (done1 || done4) lost++;
        end
        chk("abort no done", 64'(lost), 64'd0);
        $display("reset abort: sum1=%02h busy1=%0b", sum1, busy1);

        // Release reset and start immediately; 0x12 + 0x34 + 1 = 0x47
        nrst  = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b1;
        start = 1'b1;
        monitor_op("post-reset", 8'h47, 1'b0, 1'b0);
        $display("post-reset a=12 b=34 cin=1 -> sum1=%02h sum4=%02h", sum1, sum4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
